// File: rtl/keypad_pkg.sv
// Shared constants for the keypad key FIFO: register offsets, status bit map, key width.
package keypad_pkg;
  localparam logic [2:0]  KP_ADDR_DATA  = 3'b000;
  localparam logic [2:0]  KP_ADDR_STAT  = 3'b010;
  localparam int unsigned STAT_NONEMPTY = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_OVF      = 2;
  localparam int unsigned STAT_CNT_LSB  = 4;
  localparam int unsigned KEY_W         = 4;
endpackage

// File: rtl/keyfifo_mem.sv
// Key storage array: synchronous write, asynchronous read.
module keyfifo_mem
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clock,
  input  logic             write_enable,
  input  logic [PTR_W-1:0] write_ptr,
  input  logic [KEY_W-1:0] write_data,
  input  logic [PTR_W-1:0] read_ptr,
  output logic [KEY_W-1:0] read_data
);
  logic [KEY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable) mem[write_ptr] <= write_data;
  end

  assign read_data = mem[read_ptr];
endmodule

// File: rtl/keypad_key_fifo.sv
// Keypad scanner to CPU buffer: key FIFO with pop-on-read data register, status and IRQ.
// Optional repeat filter enabled by defining KEYFIFO_REPEAT_FILTER_EN.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned PTR_W         = 3,
  parameter logic [15:0] REPEAT_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        read_enable,
  input  logic [2:0]  address,
  output logic [15:0] read_data_output,
  output logic        interrupt,
  output logic        overflow_led
);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             ovf, ovf_next;
  logic             pop_q, stat_q;
  logic             pop_req, stat_req, pop, push, drop, accept;
  logic             full, nonempty;
  logic [KEY_W-1:0] rd_code;

  assign full     = (count == CNT_W'(DEPTH));
  assign nonempty = (count != '0);
  assign pop_req  = read_enable & (address == KP_ADDR_DATA);
  assign stat_req = read_enable & (address == KP_ADDR_STAT);

`ifdef KEYFIFO_REPEAT_FILTER_EN
  // Suppress a repeated code while the window counter is still running.
  logic [KEY_W-1:0] last_code;
  logic [15:0]      rep_cnt;

  assign accept = ~((key_code == last_code) && (rep_cnt != 16'd0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_code <= '0;
      rep_cnt   <= '0;
    end else if (key_valid && accept) begin
      last_code <= key_code;
      rep_cnt   <= REPEAT_CYCLES;
    end else if (rep_cnt != 16'd0) begin
      rep_cnt   <= rep_cnt - 16'd1;
    end
  end
`else
  assign accept = 1'b1;
`endif

  // A pop on a full FIFO frees the slot in the same cycle, so the push still lands.
  always_comb begin
    pop        = pop_req & ~pop_q & nonempty;
    push       = key_valid & accept & (~full | pop);
    drop       = key_valid & accept & full & ~pop;
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
    ovf_next = ovf;
    if (drop)                      ovf_next = 1'b1;
    else if (stat_req && !stat_q)  ovf_next = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      pop_q        <= 1'b0;
      stat_q       <= 1'b0;
      interrupt    <= 1'b0;
      overflow_led <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      ovf          <= ovf_next;
      pop_q        <= pop_req;
      stat_q       <= stat_req;
      interrupt    <= (count_next != '0);
      overflow_led <= ovf_next;
    end
  end

  keyfifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clock        (clock),
    .write_enable (push),
    .write_ptr    (wr_ptr),
    .write_data   (key_code),
    .read_ptr     (rd_ptr),
    .read_data    (rd_code)
  );

  // Bus read mux; idle bus reads as zero.
  always_comb begin
    read_data_output = 16'h0000;
    if (read_enable) begin
      case (address)
        KP_ADDR_DATA: if (nonempty) read_data_output = 16'(rd_code);
        KP_ADDR_STAT: begin
          read_data_output[STAT_CNT_LSB +: 4] = 4'(count);
          read_data_output[STAT_OVF]          = ovf;
          read_data_output[STAT_FULL]         = full;
          read_data_output[STAT_NONEMPTY]     = nonempty;
        end
        default: read_data_output = 16'h0000;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_key_fifo.sv
// Directed self-checking bench for keypad_key_fifo.
module tb_keypad_key_fifo;
  logic        clock = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] read_data_output;
  logic        interrupt;
  logic        overflow_led;

  int total = 0;
  int bad   = 0;

  keypad_key_fifo #(.DEPTH(8), .PTR_W(3), .REPEAT_CYCLES(16'd10)) dut (
    .clock            (clock),
    .reset            (reset),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .read_enable      (read_enable),
    .address          (address),
    .read_data_output (read_data_output),
    .interrupt        (interrupt),
    .overflow_led     (overflow_led)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    idle(1);
    key_valid = 1'b0;
  endtask

  // One-cycle strobe on the data register, then a gap so the next strobe is a fresh edge.
  task automatic rd_data(input string tag, input logic [15:0] exp_v);
    read_enable = 1'b1;
    address     = 3'b000;
    #1 chk(tag, read_data_output, exp_v);
    idle(1);
    read_enable = 1'b0;
    idle(1);
  endtask

  task automatic rd_stat(input string tag, input logic [15:0] exp_v);
    read_enable = 1'b1;
    address     = 3'b010;
    #1 chk(tag, read_data_output, exp_v);
    idle(1);
    read_enable = 1'b0;
    idle(1);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; read_enable = 1'b0; address = 3'b000;
    idle(2);
    chk("rst_irq", 16'(interrupt), 16'h0000);
    chk("rst_led", 16'(overflow_led), 16'h0000);
    chk("rst_idle_bus", read_data_output, 16'h0000);
    reset = 1'b0;
    idle(1);
    rd_stat("rst_stat", 16'h0000);

    // Basic push/pop
    push(4'h1);
    chk("irq_after_push", 16'(interrupt), 16'h0001);
    push(4'h4);
    push(4'h7);
    rd_stat("basic_stat", 16'h0031);
    rd_data("basic_pop0", 16'h0001);
    rd_data("basic_pop1", 16'h0004);
    rd_data("basic_pop2", 16'h0007);
    chk("irq_after_drain", 16'(interrupt), 16'h0000);
    rd_stat("basic_stat_empty", 16'h0000);
    rd_data("empty_data", 16'h0000);

    // Overflow: ninth key is lost
    for (int i = 0; i < 9; i++) push(4'(i));
    chk("ovf_led", 16'(overflow_led), 16'h0001);
    rd_stat("ovf_stat", 16'h0087);
    chk("ovf_led_cleared", 16'(overflow_led), 16'h0000);
    for (int i = 0; i < 8; i++) rd_data("ovf_pop", 16'(i));
    rd_stat("ovf_stat_drained", 16'h0000);

    // Long strobe pops exactly once
    push(4'h2);
    push(4'h3);
    read_enable = 1'b1;
    address     = 3'b000;
    #1 chk("long_data", read_data_output, 16'h0002);
    idle(5);
    read_enable = 1'b0;
    idle(1);
    rd_stat("long_stat", 16'h0011);
    rd_data("long_next", 16'h0003);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push(4'(i));
    rd_stat("full_stat", 16'h0083);
    read_enable = 1'b1;
    address     = 3'b000;
    key_valid   = 1'b1;
    key_code    = 4'hA;
    #1 chk("simul_data", read_data_output, 16'h0000);
    idle(1);
    read_enable = 1'b0;
    key_valid   = 1'b0;
    idle(1);
    rd_stat("simul_stat", 16'h0083);
    chk("simul_led", 16'(overflow_led), 16'h0000);
    for (int i = 1; i < 8; i++) rd_data("simul_pop", 16'(i));
    rd_data("simul_pop_a", 16'h000A);
    rd_stat("simul_drained", 16'h0000);

    // Reset mid-operation
    push(4'hC);
    push(4'hD);
    push(4'hE);
    chk("pre_rst_irq", 16'(interrupt), 16'h0001);
    reset = 1'b1;
    #2 chk("midrst_irq", 16'(interrupt), 16'h0000);
    idle(1);
    reset = 1'b0;
    idle(1);
    rd_data("midrst_data", 16'h0000);
    rd_stat("midrst_stat", 16'h0000);

`ifdef KEYFIFO_REPEAT_FILTER_EN
    // Repeat filter with a 10-cycle window
    push(4'h5);
    idle(3);
    push(4'h5);
    idle(10);
    push(4'h5);
    push(4'h6);
    rd_stat("filter_stat", 16'h0031);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_key_fifo.md
Name: keypad_key_fifo

Overview:
- Buffer between the 4x4 keypad scanner and the CPU I/O bus.
- Captures each scanned key code (4-bit hex value plus 1-cycle valid strobe) into a small FIFO, so keystrokes are not lost while the CPU is busy.
- Exposes a data register (pop on read) and a status register at the keypad I/O window (0xFFFFFC10 data, 0xFFFFFC12 status).
- Raises an interrupt while keys are pending.

Parameters:
- DEPTH, 8, number of key entries; power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); pointer width.
- REPEAT_CYCLES, 16'd50000, repeat-filter window in clocks; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- key_valid  in  1  one-cycle pulse from the scanner: a new key has been decoded.
- key_code  in  4  hex key value (0x0-0xF), qualified by key_valid.
- read_enable  in  1  CPU bus read strobe for the keypad window; level, held for 1 or more cycles.
- address  in  3  low address bits within the keypad window.
- read_data_output  out  16  combinational read data to the CPU.
- interrupt  out  1  high while the FIFO is non-empty.
- overflow_led  out  1  registered copy of the sticky overflow flag.

Behaviour:
- **Reset:** asynchronous.
  - rd_ptr, wr_ptr and count (PTR_W+1 bits) are all 0.
  - The overflow flag and both read-edge registers are 0.
  - interrupt = 0, overflow_led = 0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all pending keys.
- **Push:** key_valid=1 and count<DEPTH writes mem[wr_ptr]=key_code, then wr_ptr+1 with modulo DEPTH wrap.
- **Full drop:** key_valid=1 and count==DEPTH drops the key; the overflow flag is set (sticky).
- **Pop request:** pop_req = read_enable & (address==3'b000).
  - A register holds last-cycle pop_req.
  - A pop occurs only on its rising edge, so one long strobe pops one entry.
  - If count==0, the pop is ignored.
- **Pop action:** pop increments rd_ptr (wrap modulo DEPTH).
- **Status read:** stat_req = read_enable & (address==3'b010). The overflow flag is cleared on the rising edge of stat_req.
  - A set caused in that same cycle wins: the flag stays 1.
- **Simultaneous push and pop:**
  - Both take effect and count is unchanged.
  - This is also allowed when full: the pop frees the slot in the same cycle, so no overflow.
  - It is also allowed when empty: the pop is ignored and only the push takes effect (count becomes 1).
- **count:** +1 on push only, -1 on pop only.
- **read_data_output** (combinational; 16'h0000 when read_enable=0):
  - address 000: {12'b0, mem[rd_ptr]} if count>0, else 16'h0000. Data is valid in the same cycle as the popping edge; rd_ptr advances at the next clock.
  - address 010: {8'b0, count padded to 4 bits at [7:4], 1'b0, overflow[2], full[1], nonempty[0]}.
  - All other addresses: 16'h0000.
- **interrupt = (count != 0)**, registered from the post-update count.
  - It goes high 1 cycle after the first push.
  - It goes low 1 cycle after the last pop.
- **Latency:** key_valid to visibility at address 000 is 1 clock.

Optional Feature:
- Macro: KEYFIFO_REPEAT_FILTER_EN.
- **Defined:**
  - The block holds last_code (4 bits) and a 16-bit window counter.
  - A key_valid whose key_code equals last_code while the counter is nonzero is discarded; it is not a push and does not count as an overflow.
  - Every accepted key_valid loads last_code and sets the counter to REPEAT_CYCLES.
  - The counter decrements to 0 each cycle.
  - A different code is always accepted.
  - Reset clears the counter to 0.
- **Undefined:** every key_valid is a push candidate; no filter logic is instantiated.

Decomposition:
- Package keypad_pkg:
  - Register offsets KP_ADDR_DATA=3'b000 and KP_ADDR_STAT=3'b010.
  - Status bit indices STAT_NONEMPTY=0, STAT_FULL=1, STAT_OVF=2, STAT_CNT_LSB=4.
  - Key code width KEY_W=4.
- Sub-module keyfifo_mem: DEPTH x KEY_W register array with synchronous write and asynchronous read.
- The top level holds pointers, count, bus decode, edge detect and the filter.

Test Plan:
- **Basic push/pop:** reset, push 0x1, 0x4, 0x7 → interrupt=1 after one clock. Status read gives 16'h0031. Three data pulses return 0x0001, 0x0004, 0x0007. Then interrupt=0 and status gives 16'h0000.
- **Overflow:** push 9 keys 0x0..0x8 with DEPTH=8 → status 16'h0087 and overflow_led=1. Pops return 0x0-0x7; key 0x8 is lost. A status read clears overflow → status 16'h0000 after draining.
- **Long strobe:** hold read_enable at address 000 for 5 cycles with 2 entries → exactly one pop, count=1.
- **Simultaneous push/pop when full:** with count=8, key_valid(0xA) in the same cycle as the pop edge → count stays 8, overflow stays 0, 0xA emerges as the 8th later pop.
- **Reset mid-operation:** 3 entries pending, pulse reset → count=0, interrupt=0, data read gives 16'h0000.
- **Repeat filter (macro defined, REPEAT_CYCLES=10):**
  - 0x5 at t=0, then 0x5 at t=4 → count=1.
  - 0x5 at t=15 is accepted → count=2.
  - 0x6 at t=16 is accepted → count=3.
